// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin arbiter sharing one start/done multi-cycle multiplier among NREQ requesters
// Ports: req, a_in, b_in carry per-requester request levels and packed operands; gnt and rsp_valid are one-hot; rsp_product holds the result.
// busy is high outside IDLE; mul_clr, mul_start, mul_a, mul_b, mul_product and mul_done connect to the shared engine.
// Define MULT_SHARE_TIMEOUT_EN to add the TIMEOUT parameter, a RUN watchdog and the rsp_err output.
module mult_share_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 4
`ifdef MULT_SHARE_TIMEOUT_EN
  , parameter int TIMEOUT = 32
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_in,
  input  logic [NREQ*WIDTH-1:0]   b_in,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]      rsp_product,
  output logic                    busy,
  output logic                    mul_clr,
  output logic                    mul_start,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  input  logic [2*WIDTH-1:0]      mul_product,
  input  logic                    mul_done
`ifdef MULT_SHARE_TIMEOUT_EN
  , output logic                  rsp_err
`endif
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, CLR, RUN, RESP} state_t;
  state_t state;
  logic [PW-1:0] ptr, win, win_q;
  logic [PW:0] s;
  logic [NREQ-1:0] rot;
  logic found, first;
`ifdef MULT_SHARE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`endif
  // rot[k] is the request k positions after ptr, so the lowest set bit of rot is the round-robin winner
  assign rot = NREQ'({req, req} >> ptr);
  always_comb begin
    found = 1'b0;
    win = '0;
    s = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, ptr} + (PW+1)'(k);
      if (!found && rot[k]) begin
        found = 1'b1;
        win = s >= (PW+1)'(NREQ) ? PW'(s - (PW+1)'(NREQ)) : PW'(s);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      win_q <= '0;
      first <= 1'b0;
      gnt <= '0;
      rsp_valid <= '0;
      rsp_product <= '0;
      busy <= 1'b0;
      mul_clr <= 1'b0;
      mul_start <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
`ifdef MULT_SHARE_TIMEOUT_EN
      rsp_err <= 1'b0;
      cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (found) begin
          state <= CLR;
          win_q <= win;
          gnt <= NREQ'(1) << win;
          mul_a <= WIDTH'(a_in >> (win * WIDTH));
          mul_b <= WIDTH'(b_in >> (win * WIDTH));
          mul_clr <= 1'b1;
          busy <= 1'b1;
        end
        CLR: begin
          state <= RUN;
          mul_clr <= 1'b0;
          mul_start <= 1'b1;
          first <= 1'b1;
`ifdef MULT_SHARE_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        RUN: begin
          // done seen in the first RUN cycle may still be the stale sticky value from the previous operation
          first <= 1'b0;
          if (!first && mul_done) begin
            state <= RESP;
            rsp_product <= mul_product;
            rsp_valid <= gnt;
            mul_start <= 1'b0;
          end
`ifdef MULT_SHARE_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            state <= RESP;
            rsp_product <= '0;
            rsp_valid <= gnt;
            rsp_err <= 1'b1;
            mul_start <= 1'b0;
          end else cnt <= cnt + 1'b1;
`endif
        end
        default: begin
          state <= IDLE;
          gnt <= '0;
          rsp_valid <= '0;
          busy <= 1'b0;
          ptr <= win_q == PW'(NREQ - 1) ? '0 : win_q + 1'b1;
`ifdef MULT_SHARE_TIMEOUT_EN
          rsp_err <= 1'b0;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed bench with a transaction-level timeline model and a 5-cycle sticky-done engine
module tb_mult_share_arbiter;
  localparam int NREQ = 4;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*W-1:0] a_in = '0;
  logic [NREQ*W-1:0] b_in = '0;
  logic [NREQ-1:0] gnt, rsp_valid;
  logic [2*W-1:0] rsp_product, mul_product;
  logic busy, mul_clr, mul_start;
  logic [W-1:0] mul_a, mul_b;
  logic mul_done = 1'b0;
  int e_cnt = 0;
`ifdef MULT_SHARE_TIMEOUT_EN
  logic rsp_err;
`endif
  int n_tests = 0;
  int n_fail = 0;
  int log_w[$];
  int log_p[$];
  int m_busy = 0, m_t = 0, m_w = 0, m_ptr = 0, m_rst = 1, m_a = 0, m_b = 0, m_j = 0;
  int lat;

  mult_share_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_product(rsp_product), .busy(busy),
    .mul_clr(mul_clr), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_done(mul_done)
`ifdef MULT_SHARE_TIMEOUT_EN
    , .rsp_err(rsp_err)
`endif
  );

  always #5 clk = ~clk;

  // shared engine: cleared by rst or mul_clr, done rises on the 5th start cycle and stays until cleared
  always @(posedge clk) begin
    if (rst || mul_clr) begin
      e_cnt <= 0;
      mul_done <= 1'b0;
    end else if (mul_start && !mul_done) begin
      e_cnt <= e_cnt + 1;
      if (e_cnt == 4) mul_done <= 1'b1;
    end
  end
  assign mul_product = mul_done ? {4'b0, mul_a} * {4'b0, mul_b} : '0;

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: an operation occupies 8 edges after the granting edge (clr, start, 5-cycle engine + ignored first RUN cycle, response), then one idle edge
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_busy = 0;
      m_ptr = 0;
      m_rst = 1;
    end else begin
      m_rst = 0;
      if (m_busy != 0) begin
        m_t++;
        if (m_t == 9) begin
          m_busy = 0;
          m_ptr = (m_w + 1) % NREQ;
        end
      end else
        for (int k = 0; k < NREQ; k++) begin
          m_j = (m_ptr + k) % NREQ;
          if (req[m_j]) begin
            m_busy = 1;
            m_t = 1;
            m_w = m_j;
            m_a = int'(a_in[m_j*W +: W]);
            m_b = int'(b_in[m_j*W +: W]);
            break;
          end
        end
    end
    #1;
    check("gnt", int'(gnt), m_busy != 0 ? 1 << m_w : 0);
    check("busy", int'(busy), m_busy);
    check("mul_clr", int'(mul_clr), (m_busy != 0 && m_t == 1) ? 1 : 0);
    check("mul_start", int'(mul_start), (m_busy != 0 && m_t >= 2 && m_t <= 7) ? 1 : 0);
    check("rsp_valid", int'(rsp_valid), (m_busy != 0 && m_t == 8) ? 1 << m_w : 0);
    if (m_busy != 0 && m_t == 8) check("rsp_product", int'(rsp_product), m_a * m_b);
    if (m_busy != 0) begin
      check("mul_a", int'(mul_a), m_a);
      check("mul_b", int'(mul_b), m_b);
    end
    if (m_rst != 0) check("rst_product", int'(rsp_product), 0);
`ifdef MULT_SHARE_TIMEOUT_EN
    check("rsp_err", int'(rsp_err), 0);
`endif
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NREQ; i++)
      if (rsp_valid[i]) begin
        log_w.push_back(i);
        log_p.push_back(int'(rsp_product));
      end
  end

  task automatic set_op(int i, int a, int b);
    a_in[i*W +: W] = W'(a);
    b_in[i*W +: W] = W'(b);
  endtask

  task automatic rst_dut();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    log_w.delete();
    log_p.delete();
  endtask

  task automatic serve(int maxc);
    int c = 0;
    while ((req != 0 || busy) && c < maxc) begin
      @(negedge clk);
      c++;
      for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) req[i] = 1'b0;
    end
    check("serve_done", (req == 0 && !busy) ? 1 : 0, 1);
  endtask

  task automatic exp_log(string name, int i, int w, int p);
    check({name, "_w"}, i < log_w.size() ? log_w[i] : -1, w);
    check({name, "_p"}, i < log_p.size() ? log_p[i] : -1, p);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    rst_dut();
    check("reset_gnt", int'(gnt), 0);
    check("reset_busy", int'(busy), 0);
    // single request, latency from the sampling edge
    set_op(0, 3, 5);
    req = 4'b0001;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rsp_valid == 0 && lat < 20);
    check("s1_latency", lat, 8);
    check("s1_rsp_valid", int'(rsp_valid), 1);
    check("s1_product", int'(rsp_product), 15);
    req = '0;
    @(negedge clk);
    check("s1_busy_after", int'(busy), 0);
    // all requesters at once
    rst_dut();
    set_op(0, 2, 3);
    set_op(1, 4, 4);
    set_op(2, 15, 15);
    set_op(3, 7, 0);
    req = 4'b1111;
    serve(80);
    check("s2_count", log_w.size(), 4);
    exp_log("s2_0", 0, 0, 6);
    exp_log("s2_1", 1, 1, 16);
    exp_log("s2_2", 2, 2, 225);
    exp_log("s2_3", 3, 3, 0);
    // fairness between two continuous requesters
    rst_dut();
    set_op(0, 1, 2);
    set_op(2, 3, 3);
    req = 4'b0101;
    lat = 0;
    while (log_w.size() < 4 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    req = '0;
    serve(40);
    exp_log("s3_0", 0, 0, 2);
    exp_log("s3_1", 1, 2, 9);
    exp_log("s3_2", 2, 0, 2);
    exp_log("s3_3", 3, 2, 9);
    // operand change and request drop after grant
    rst_dut();
    set_op(1, 9, 9);
    req = 4'b0010;
    repeat (2) @(negedge clk);
    check("s4_gnt", int'(gnt), 2);
    set_op(1, 1, 9);
    req = '0;
    serve(40);
    check("s4_count", log_w.size(), 1);
    exp_log("s4", 0, 1, 81);
    // reset during RUN
    rst_dut();
    set_op(1, 2, 2);
    req = 4'b0010;
    repeat (4) @(negedge clk);
    check("s5_in_run", int'(mul_start), 1);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("s5_rst_gnt", int'(gnt), 0);
    check("s5_rst_busy", int'(busy), 0);
    check("s5_rst_rsp", int'(rsp_valid), 0);
    check("s5_rst_start", int'(mul_start), 0);
    check("s5_rst_a", int'(mul_a), 0);
    rst = 1'b0;
    set_op(3, 6, 7);
    req = 4'b1000;
    serve(40);
    check("s5_count", log_w.size(), 1);
    exp_log("s5", 0, 3, 42);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
